// File: rtl/reg_file.sv
// reg_file: 16-entry register file with two combinational read ports, one
// write-back port with same-cycle bypass, a RUN/HALTED state machine that
// freezes the architectural state once a HALT retires, and a 16-bit count
// of committed register writes.
module reg_file #(
  parameter int DATA_W   = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              halt_in,
  input  logic [3:0]        rd0_addr,
  input  logic [3:0]        rd1_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic [DATA_W-1:0] rd1_data,
  output logic              halted,
  output logic [15:0]       wr_count
);

  localparam int NUM_REGS = 16;

  // Two-state retirement FSM; HALTED is absorbing until reset.
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [0:0]        state;
  logic              in_run;
  logic              wr_is_r0;
  logic              commit;

  // Decide whether the write-back transaction this cycle is architecturally
  // committed. The same signal gates the register update, the bypass and the
  // counter, so a suppressed write can never leak through any of them.
  // Gating with rst_n keeps the bypass silent while reset is held, so every
  // read returns zero during reset. Evaluating in_run first means an unknown
  // we while HALTED still resolves commit to a clean 0.
  always_comb begin
    in_run   = (state == ST_RUN);
    wr_is_r0 = ZERO_EN && (wr_addr == 4'd0);
    commit   = rst_n && in_run && !halt_in && we && !wr_is_r0;
  end

  // Next-state logic for the FSM: leave RUN when a HALT marker retires,
  // independent of we; HALTED holds until rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (in_run && halt_in) begin
      state <= ST_HALTED;
    end
  end

  assign halted = (state == ST_HALTED);

  // Register array update. All entries clear on reset so that a post-reset
  // debug dump reads all zeros.
  // NOTE: this storage is deliberately flops with a reset, not a RAM macro;
  //       resetting a memory array forces it into flip-flops, which is what
  //       the clear-on-reset behaviour requires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Count committed writes only; wraps silently at 16 bits and freezes in
  // HALTED because commit is never asserted there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Read port 0: R0 hard-wired to zero when enabled, then bypass of a
  // committing write to the same address, otherwise the stored value.
  // NOTE: rd0_data is assigned first in every path of this always_comb so no
  //       latch is inferred when none of the branches match.
  always_comb begin
    rd0_data = regs[rd0_addr];
    if (ZERO_EN && (rd0_addr == 4'd0)) begin
      rd0_data = '0;
    end else if (commit && (rd0_addr == wr_addr)) begin
      rd0_data = wr_data;
    end
  end

  // Read port 1: same priority as port 0, evaluated independently so both
  // ports may bypass the same write in one cycle.
  always_comb begin
    rd1_data = regs[rd1_addr];
    if (ZERO_EN && (rd1_addr == 4'd0)) begin
      rd1_data = '0;
    end else if (commit && (rd1_addr == wr_addr)) begin
      rd1_data = wr_data;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed test of reg_file with default parameters
// (DATA_W=16, ZERO_REG=1). Inputs change on the falling edge and outputs are
// sampled shortly after, well away from the rising edge.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        halt_in;
  logic [3:0]  rd0_addr;
  logic [3:0]  rd1_addr;
  logic [15:0] rd0_data;
  logic [15:0] rd1_data;
  logic        halted;
  logic [15:0] wr_count;

  int n_checks;
  int n_fails;

  // Expected register contents maintained by the bench.
  logic [15:0] exp_regs [16];

  reg_file #(.DATA_W(16), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .halt_in  (halt_in),
    .rd0_addr (rd0_addr),
    .rd1_addr (rd1_addr),
    .rd0_data (rd0_data),
    .rd1_data (rd1_data),
    .halted   (halted),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read every address on both ports and compare against exp_regs.
  task automatic dump_check(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd0_addr = 4'(a);
      rd1_addr = 4'(15 - a);
      #1;
      check($sformatf("%s rd0 r%0d", tag, a), {16'h0, rd0_data}, {16'h0, exp_regs[a]});
      check($sformatf("%s rd1 r%0d", tag, 15 - a), {16'h0, rd1_data}, {16'h0, exp_regs[15 - a]});
    end
  endtask

  // Apply one committed write on the next rising edge.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    exp_regs[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;

    rst_n = 1'b0; we = 1'b0; wr_addr = 4'd0; wr_data = 16'h0;
    halt_in = 1'b0; rd0_addr = 4'd0; rd1_addr = 4'd0;

    // While held in reset, an attempted write must neither bypass nor land.
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd5; wr_data = 16'hFFFF; rd0_addr = 4'd5; rd1_addr = 4'd5;
    #1;
    check("reset no bypass rd0", {16'h0, rd0_data}, 32'h0);
    check("reset no bypass rd1", {16'h0, rd1_data}, 32'h0);
    @(negedge clk);
    we = 1'b0;
    dump_check("reset");
    check("reset halted", {31'h0, halted}, 32'h0);
    check("reset wr_count", {16'h0, wr_count}, 32'h0);

    // Release reset; the very next rising edge may commit a write.
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd0_addr = 4'd5; rd1_addr = 4'd5;
    #1;
    check("bypass rd0", {16'h0, rd0_data}, 32'hBEEF);
    check("bypass rd1", {16'h0, rd1_data}, 32'hBEEF);
    @(posedge clk);
    exp_regs[5] = 16'hBEEF;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("r5 stored rd0", {16'h0, rd0_data}, 32'hBEEF);
    check("r5 stored rd1", {16'h0, rd1_data}, 32'hBEEF);
    check("wr_count after first write", {16'h0, wr_count}, 32'd1);

    // R0 is hard-wired to zero and a write to it is not counted.
    we = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rd0_addr = 4'd0; rd1_addr = 4'd0;
    #1;
    check("r0 same cycle rd0", {16'h0, rd0_data}, 32'h0);
    check("r0 same cycle rd1", {16'h0, rd1_data}, 32'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("r0 next cycle", {16'h0, rd0_data}, 32'h0);
    check("wr_count after r0 write", {16'h0, wr_count}, 32'd1);

    do_write(4'd3, 16'h0011);
    do_write(4'd15, 16'hFFFF);

    // Independent bypass: port 0 sees the write to R7, port 1 reads R3.
    we = 1'b1; wr_addr = 4'd7; wr_data = 16'hA5A5; rd0_addr = 4'd7; rd1_addr = 4'd3;
    #1;
    check("split bypass rd0", {16'h0, rd0_data}, 32'hA5A5);
    check("split bypass rd1", {16'h0, rd1_data}, 32'h0011);
    @(posedge clk);
    exp_regs[7] = 16'hA5A5;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("wr_count before halt", {16'h0, wr_count}, 32'd4);

    // Write and HALT together: write dropped, no bypass, halted next cycle.
    we = 1'b1; wr_addr = 4'd3; wr_data = 16'h00FF; halt_in = 1'b1;
    rd0_addr = 4'd3; rd1_addr = 4'd3;
    #1;
    check("halt no bypass rd0", {16'h0, rd0_data}, 32'h0011);
    check("halt no bypass rd1", {16'h0, rd1_data}, 32'h0011);
    check("halted not yet", {31'h0, halted}, 32'h0);
    @(negedge clk);
    we = 1'b0; halt_in = 1'b0;
    #1;
    check("halted raised", {31'h0, halted}, 32'h1);
    check("r3 kept", {16'h0, rd0_data}, 32'h0011);
    check("wr_count after halt", {16'h0, wr_count}, 32'd4);

    // Ten attempted writes in HALTED, plus one cycle with we unknown.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      we = 1'b1;
      wr_addr = 4'($urandom_range(1, 15));
      wr_data = 16'($urandom);
      rd0_addr = wr_addr;
      #1;
      check($sformatf("halted no bypass %0d", i), {16'h0, rd0_data}, {16'h0, exp_regs[wr_addr]});
    end
    @(negedge clk);
    we = 1'bx; wr_addr = 4'd9; wr_data = 16'h5555;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("halted stays", {31'h0, halted}, 32'h1);
    check("wr_count frozen", {16'h0, wr_count}, 32'd4);
    dump_check("halted dump");

    // Asynchronous reset mid-cycle with a write pending.
    @(negedge clk);
    we = 1'b1; wr_addr = 4'd9; wr_data = 16'h1234;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
    check("async reset halted", {31'h0, halted}, 32'h0);
    check("async reset wr_count", {16'h0, wr_count}, 32'h0);
    @(negedge clk);
    we = 1'b0;
    dump_check("async reset");

    // Counter wrap: 65,537 committed writes leave wr_count at 1.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 65535) begin
        #1;
        check("wr_count at 0xFFFF", {16'h0, wr_count}, 32'hFFFF);
      end
      we = 1'b1;
      wr_addr = 4'((i % 15) + 1);
      wr_data = 16'(i);
    end
    @(negedge clk);
    we = 1'b0;
    #1;
    check("wr_count wrapped", {16'h0, wr_count}, 32'h0001);
    // Last write: i=65536 -> addr (65536 % 15)+1 = 2, data 0x0000;
    // i=65535 -> addr 1, data 0xFFFF.
    rd0_addr = 4'd1; rd1_addr = 4'd2;
    #1;
    check("wrap last r1", {16'h0, rd0_data}, 32'hFFFF);
    check("wrap last r2", {16'h0, rd1_data}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Guard against a hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
